// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX pipeline stage: ALU op encodings, the zero
// register index and a small source-match helper used by hazard and forwarding logic.
package id_ex_stage_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [5:0] ALU_ADD  = 6'd0;
  localparam logic [5:0] ALU_SUB  = 6'd1;
  localparam logic [5:0] ALU_AND  = 6'd2;
  localparam logic [5:0] ALU_OR   = 6'd3;
  localparam logic [5:0] ALU_XOR  = 6'd4;
  localparam logic [5:0] ALU_SLL  = 6'd5;
  localparam logic [5:0] ALU_SRL  = 6'd6;
  localparam logic [5:0] ALU_SRA  = 6'd7;
  localparam logic [5:0] ALU_SLT  = 6'd8;
  localparam logic [5:0] ALU_SLTU = 6'd9;

  // True when a valid producer writes the given nonzero source register.
  function automatic logic src_match(input logic       valid,
                                     input logic [4:0] src,
                                     input logic [4:0] rd);
    return valid && (src == rd) && (src != REG_ZERO);
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand resolver for one source register.
// With ID_EX_FWD_EN defined: held-entry result beats the memory-stage result, which
// beats register-file data. Without it: register-file data only. x0 always reads 0.
module id_ex_stage_fwd_mux
  import id_ex_stage_pkg::*;
(
  input  logic [4:0]  src,
  input  logic [31:0] rf_data,
  input  logic        held_valid,
  input  logic        held_is_load,
  input  logic [4:0]  held_rd,
  input  logic [31:0] held_data,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic [31:0] value
);

`ifdef ID_EX_FWD_EN
  // Priority select: x0, held ALU entry (not a load), memory stage, register file.
  always_comb begin
    value = rf_data;
    if (src == REG_ZERO) begin
      value = 32'h0;
    end else if (!held_is_load && src_match(held_valid, src, held_rd)) begin
      value = held_data;
    end else if (src_match(mem_valid, src, mem_rd)) begin
      value = mem_data;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{held_valid, held_is_load, held_rd, held_data, mem_valid, mem_rd, mem_data};

  // Register file is write-before-read here; hazards are covered by stalling.
  always_comb begin
    value = (src == REG_ZERO) ? 32'h0 : rf_data;
  end
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX single-entry pipeline register with operand resolution and hazard stall.
// Optional feature macro: ID_EX_FWD_EN enables operand forwarding; without it the
// stage stalls on any RAW dependency against the held entry or the memory stage.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_alu_op,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_pc,
  input  logic        in_use_imm,
  input  logic        in_use_pc,
  input  logic        in_is_load,
  input  logic [31:0] alu_result,
  input  logic        mem_fwd_valid,
  input  logic [4:0]  mem_fwd_rd,
  input  logic [31:0] mem_fwd_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [5:0]  alu_op,
  output logic [4:0]  out_rd,
  output logic [31:0] out_store_data,
  output logic        out_is_load
);

  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        rs1_hit;
  logic        rs2_hit;
  logic        hazard_stall;
  logic        accept;

  id_ex_stage_fwd_mux u_fwd_mux_rs1 (
    .src          (in_rs1),
    .rf_data      (in_rs1_data),
    .held_valid   (out_valid),
    .held_is_load (out_is_load),
    .held_rd      (out_rd),
    .held_data    (alu_result),
    .mem_valid    (mem_fwd_valid),
    .mem_rd       (mem_fwd_rd),
    .mem_data     (mem_fwd_data),
    .value        (rs1_val)
  );

  id_ex_stage_fwd_mux u_fwd_mux_rs2 (
    .src          (in_rs2),
    .rf_data      (in_rs2_data),
    .held_valid   (out_valid),
    .held_is_load (out_is_load),
    .held_rd      (out_rd),
    .held_data    (alu_result),
    .mem_valid    (mem_fwd_valid),
    .mem_rd       (mem_fwd_rd),
    .mem_data     (mem_fwd_data),
    .value        (rs2_val)
  );

  // Hazard detection and upstream handshake; rs2 always counts (it may be store data).
  always_comb begin
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
`ifdef ID_EX_FWD_EN
    rs1_hit = out_is_load && src_match(out_valid, in_rs1, out_rd);
    rs2_hit = out_is_load && src_match(out_valid, in_rs2, out_rd);
`else
    rs1_hit = src_match(out_valid, in_rs1, out_rd) ||
              src_match(mem_fwd_valid, in_rs1, mem_fwd_rd);
    rs2_hit = src_match(out_valid, in_rs2, out_rd) ||
              src_match(mem_fwd_valid, in_rs2, mem_fwd_rd);
`endif
    hazard_stall = in_valid && ((rs1_hit && !in_use_pc) || rs2_hit);
    // Flush always drains upstream, so the kill never deadlocks on a stall.
    in_ready     = flush || ((!out_valid || out_ready) && !hazard_stall);
    accept       = in_valid && in_ready && !flush;
  end

  // Stage register: flush kills, accept loads, consumption without refill empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      alu_a          <= 32'h0;
      alu_b          <= 32'h0;
      alu_op         <= ALU_ADD;
      out_rd         <= REG_ZERO;
      out_store_data <= 32'h0;
      out_is_load    <= 1'b0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        alu_a          <= in_use_pc ? in_pc : rs1_val;
        alu_b          <= in_use_imm ? in_imm : rs2_val;
        alu_op         <= in_alu_op;
        out_rd         <= in_rd;
        out_store_data <= rs2_val;
        out_is_load    <= in_is_load;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage; expectations adapt to whether ID_EX_FWD_EN is set.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

`ifdef ID_EX_FWD_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_alu_op = '0;
  logic [4:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic [31:0] in_rs1_data = '0, in_rs2_data = '0, in_imm = '0, in_pc = '0;
  logic        in_use_imm = 1'b0, in_use_pc = 1'b0, in_is_load = 1'b0;
  logic [31:0] alu_result = '0;
  logic        mem_fwd_valid = 1'b0;
  logic [4:0]  mem_fwd_rd = '0;
  logic [31:0] mem_fwd_data = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] alu_a, alu_b, out_store_data;
  logic [5:0]  alu_op;
  logic [4:0]  out_rd;
  logic        out_is_load;

  id_ex_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_alu_op      (in_alu_op),
    .in_rs1         (in_rs1),
    .in_rs2         (in_rs2),
    .in_rd          (in_rd),
    .in_rs1_data    (in_rs1_data),
    .in_rs2_data    (in_rs2_data),
    .in_imm         (in_imm),
    .in_pc          (in_pc),
    .in_use_imm     (in_use_imm),
    .in_use_pc      (in_use_pc),
    .in_is_load     (in_is_load),
    .alu_result     (alu_result),
    .mem_fwd_valid  (mem_fwd_valid),
    .mem_fwd_rd     (mem_fwd_rd),
    .mem_fwd_data   (mem_fwd_data),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .alu_a          (alu_a),
    .alu_b          (alu_b),
    .alu_op         (alu_op),
    .out_rd         (out_rd),
    .out_store_data (out_store_data),
    .out_is_load    (out_is_load)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] st;
    logic [5:0]  op;
    logic [4:0]  rd;
    logic        ld;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // Monitor: every transfer downstream is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        errors++;
        $display("FAIL unexpected_out: got entry rd=%0d, want no entry", out_rd);
      end else begin
        mon_e = exp_q.pop_front();
        chk("alu_a", alu_a, mon_e.a);
        chk("alu_b", alu_b, mon_e.b);
        chk("store_data", out_store_data, mon_e.st);
        chk("alu_op", {26'd0, alu_op}, {26'd0, mon_e.op});
        chk("out_rd", {27'd0, out_rd}, {27'd0, mon_e.rd});
        chk("is_load", {31'd0, out_is_load}, {31'd0, mon_e.ld});
      end
    end
  end

  task automatic drive(input logic [5:0] op, input logic [4:0] rs1, input logic [31:0] d1,
                       input logic [4:0] rs2, input logic [31:0] d2, input logic [4:0] rd,
                       input logic [31:0] imm, input logic use_imm, input logic use_pc,
                       input logic [31:0] pc, input logic ld);
    in_valid = 1'b1;  in_alu_op = op;
    in_rs1 = rs1;     in_rs1_data = d1;
    in_rs2 = rs2;     in_rs2_data = d2;
    in_rd = rd;       in_imm = imm;
    in_use_imm = use_imm; in_use_pc = use_pc; in_pc = pc; in_is_load = ld;
  endtask

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] st,
                              input logic [5:0] op, input logic [4:0] rd, input logic ld);
    exp_t e;
    e.a = a; e.b = b; e.st = st; e.op = op; e.rd = rd; e.ld = ld;
    return e;
  endfunction

  // Waits for the handshake with a bounded stall budget; reports stall cycles and
  // whether the output register was empty in the accepting cycle.
  task automatic wait_accept(input exp_t e, input bit push, output int stalls,
                             output logic ov_at_accept);
    stalls = 0;
    ov_at_accept = 1'b0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        ov_at_accept = out_valid;
        if (push) exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      stalls++;
      if (stalls > 20) begin
        tests++;
        errors++;
        $display("FAIL accept_timeout: got %0d stall cycles, want acceptance", stalls);
        in_valid = 1'b0;
        return;
      end
    end
  endtask

  int   st;
  logic ov;
  exp_t e;

  initial begin
    #1 rst_n = 1'b0;
    #11;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_store", out_store_data, 32'd0);
    chk("rst_alu_op", {26'd0, alu_op}, 32'd0);
    chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
    chk("rst_is_load", {31'd0, out_is_load}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // x0 never forwards, even with a valid memory result targeting x0.
    mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd0; mem_fwd_data = 32'hCAFE_F00D;
    drive(ALU_ADD, 5'd0, 32'h1234, 5'd0, 32'h5678, 5'd5, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    wait_accept(mk(32'h0, 32'h0, 32'h0, ALU_ADD, 5'd5, 1'b0), 1'b1, st, ov);
    chk("x0_stalls", st, 32'd0);
    mem_fwd_valid = 1'b0;

    // ADDI x1, x0, 5 issued back-to-back behind the x0 entry.
    drive(ALU_ADD, 5'd0, 32'h0, 5'd0, 32'h0, 5'd1, 32'd5, 1'b1, 1'b0, 32'd0, 1'b0);
    wait_accept(mk(32'h0, 32'd5, 32'h0, ALU_ADD, 5'd1, 1'b0), 1'b1, st, ov);
    chk("addi_stalls", st, 32'd0);

    // ADD x2, x1, x1: forwarded from the held entry, or stall then fresh RF data.
    alu_result = 32'd5;
    drive(ALU_ADD, 5'd1, FwdEn ? 32'd0 : 32'd5, 5'd1, FwdEn ? 32'd0 : 32'd5, 5'd2,
          32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    wait_accept(mk(32'd5, 32'd5, 32'd5, ALU_ADD, 5'd2, 1'b0), 1'b1, st, ov);
    chk("b2b_stalls", st, FwdEn ? 32'd0 : 32'd1);
    alu_result = 32'd0;

    // SUB x7, x6, x3 with x3 in flight in the memory stage.
    e = mk(32'd7, 32'hDEAD_BEEF, 32'hDEAD_BEEF, ALU_SUB, 5'd7, 1'b0);
    mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd3; mem_fwd_data = 32'hDEAD_BEEF;
    drive(ALU_SUB, 5'd6, 32'd7, 5'd3, 32'd0, 5'd7, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
`ifndef ID_EX_FWD_EN
    @(negedge clk);
    chk("mem_hazard_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    mem_fwd_valid = 1'b0;
    in_rs2_data = 32'hDEAD_BEEF;
`endif
    wait_accept(e, 1'b1, st, ov);
    chk("memfwd_stalls", st, 32'd0);
    mem_fwd_valid = 1'b0;

    // AUIPC-like: rs1 matches held rd 7 but is unused because a = pc.
    drive(ALU_ADD, 5'd7, 32'h55, 5'd0, 32'd0, 5'd8, 32'h2000, 1'b1, 1'b1, 32'h100, 1'b0);
    wait_accept(mk(32'h100, 32'h2000, 32'h0, ALU_ADD, 5'd8, 1'b0), 1'b1, st, ov);
    chk("use_pc_stalls", st, 32'd0);

    // LW x4, 4(x9) followed by a dependent ADD: one stall, one bubble, then accept.
    drive(ALU_ADD, 5'd9, 32'd100, 5'd0, 32'd0, 5'd4, 32'd4, 1'b1, 1'b0, 32'd0, 1'b1);
    wait_accept(mk(32'd100, 32'd4, 32'h0, ALU_ADD, 5'd4, 1'b1), 1'b1, st, ov);
    chk("lw_stalls", st, 32'd0);
    drive(ALU_ADD, 5'd4, 32'h44, 5'd0, 32'd0, 5'd9, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    wait_accept(mk(32'h44, 32'h0, 32'h0, ALU_ADD, 5'd9, 1'b0), 1'b1, st, ov);
    chk("loaduse_stalls", st, 32'd1);
    chk("loaduse_bubble", {31'd0, ov}, 32'd0);
    repeat (2) @(posedge clk);
    #1;

    // Backpressure holds the entry; flush then kills it.
    out_ready = 1'b0;
    drive(ALU_XOR, 5'd10, 32'd11, 5'd12, 32'd22, 5'd13, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    wait_accept(e, 1'b0, st, ov);
    drive(ALU_OR, 5'd14, 32'd1, 5'd15, 32'd2, 5'd16, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_alu_a", alu_a, 32'd11);
      chk("bp_alu_b", alu_b, 32'd22);
      chk("bp_ready", {31'd0, in_ready}, 32'd0);
    end
    chk("bp_alu_op", {26'd0, alu_op}, {26'd0, ALU_XOR});
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);

    // Async reset while a load-use stall is pending under backpressure.
    @(posedge clk);
    #1;
    drive(ALU_ADD, 5'd9, 32'd100, 5'd0, 32'd0, 5'd4, 32'd4, 1'b1, 1'b0, 32'd0, 1'b1);
    wait_accept(e, 1'b0, st, ov);
    drive(ALU_ADD, 5'd4, 32'h77, 5'd0, 32'd0, 5'd10, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    chk("stall_ready", {31'd0, in_ready}, 32'd0);
    chk("stall_valid", {31'd0, out_valid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_alu_a", alu_a, 32'd0);
    chk("arst_alu_b", alu_b, 32'd0);
    chk("arst_is_load", {31'd0, out_is_load}, 32'd0);
    chk("arst_out_rd", {27'd0, out_rd}, 32'd0);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    exp_q.push_back(mk(32'h77, 32'h0, 32'h0, ALU_ADD, 5'd10, 1'b0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports, clock and reset first: clk in 1 system clock; rst_n in 1 asynchronous active-low reset.
REQ-002 SHALL have in_valid in 1, in_ready out 1: upstream decode handshake.
REQ-003 SHALL have in_alu_op in 6, in_rs1 in 5, in_rs2 in 5, in_rd in 5: decoded op and register indices.
REQ-004 SHALL have in_rs1_data in 32, in_rs2_data in 32, in_imm in 32, in_pc in 32: register-file read data, immediate, PC.
REQ-005 SHALL have in_use_imm in 1 (b = imm), in_use_pc in 1 (a = pc), in_is_load in 1.
REQ-006 SHALL have alu_result in 32: ALU output for the entry currently held in this stage.
REQ-007 SHALL have mem_fwd_valid in 1, mem_fwd_rd in 5, mem_fwd_data in 32: result of the instruction one stage further on.
REQ-008 SHALL have flush in 1: synchronous pipeline kill.
REQ-009 SHALL have out_valid out 1, out_ready in 1: downstream (ALU/execute) handshake.
REQ-010 SHALL have alu_a out 32, alu_b out 32, alu_op out 6, out_rd out 5, out_store_data out 32, out_is_load out 1.

Function
REQ-011 SHALL be a single-entry registered stage; latency from accepted input to out_valid is 1 cycle; all outputs are flops.
REQ-012 SHALL accept when in_valid && in_ready; in_ready = (!out_valid || out_ready) && !hazard_stall.
REQ-013 SHALL, when out_valid && out_ready and no new accept, clear out_valid next cycle.
REQ-014 SHALL hold all outputs stable while out_valid && !out_ready.
REQ-015 SHALL resolve each source operand at capture: priority (1) held entry (out_valid, !out_is_load, out_rd == src, src != 0) -> alu_result; (2) mem_fwd_valid && mem_fwd_rd == src && src != 0 -> mem_fwd_data; (3) register-file data.
REQ-016 SHALL never forward for source index 0; x0 operand SHALL be 32'h0 regardless of in_rsX_data.
REQ-017 SHALL set alu_a = in_use_pc ? in_pc : resolved rs1; alu_b = in_use_imm ? in_imm : resolved rs2; out_store_data = resolved rs2 always.
REQ-018 SHALL raise hazard_stall (load-use) when out_valid && out_is_load && out_rd != 0 and out_rd matches an operand-used source (rs1 unless in_use_pc; rs2 unless in_use_imm and not a store-data use -- rs2 always counted).
REQ-019 SHALL, during load-use stall with out_ready high, drain the load and present a bubble (out_valid=0) for one cycle, then accept.
REQ-020 SHALL on flush: in_ready=1, input discarded, out_valid=0 next cycle; flush overrides capture and stall.
REQ-021 SHALL register a new entry in the same cycle the old one is consumed (full throughput, no bubble without hazard).

Reset
REQ-022 SHALL on rst_n low immediately clear out_valid, alu_a, alu_b, out_store_data to 0, alu_op to 0, out_rd to 0, out_is_load to 0.
REQ-023 SHALL, on reset mid-transfer, drop the held entry; first accept allowed on the first clk edge after rst_n deasserts.

Configuration
REQ-024 SHALL, with ID_EX_FWD_EN defined, implement REQ-015 forwarding.
REQ-025 SHALL, without ID_EX_FWD_EN, use register-file data only and extend hazard_stall to any nonzero source matching held out_rd (out_valid) or mem_fwd_rd (mem_fwd_valid); register file SHALL be write-before-read.

Structure
REQ-026 SHALL take alu_op encodings and REG_ZERO (5'd0) from the shared constants include; no local opcode literals.
REQ-027 SHALL instantiate sub-module fwd_mux twice (rs1, rs2): inputs src index, rf data, held entry, mem fwd; output resolved value.

Verification
REQ-028 Back-to-back: ADDI x1,x0,5 then ADD x2,x1,x1 with alu_result=5 -> second entry alu_a=5, alu_b=5, no bubble.
REQ-029 Mem forward: mem_fwd_valid=1, rd=3, data=32'hDEAD_BEEF, in_rs2=3, rf data 0 -> alu_b=32'hDEADBEEF.
REQ-030 Load-use: LW x4 held, next in_rs1=4 -> in_ready=0 one cycle, bubble, then accepted.
REQ-031 x0: in_rs1=0, in_rs1_data=32'h1234, mem_fwd_rd=0 valid -> alu_a=0.
REQ-032 Backpressure + flush: out_ready=0 for 3 cycles holds outputs; flush asserted -> out_valid=0 next cycle.
REQ-033 Async reset asserted mid-stall -> out_valid=0 without clock edge; build both with and without ID_EX_FWD_EN.
